// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier for signed two's-complement operands.
// Operands are captured on a start pulse in IDLE; the full-width product is
// registered WIDTH cycles later, accompanied by a one-cycle done pulse, and
// then held until the next multiplication completes.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands are sampled on the start edge
// CALC  | performing WIDTH Booth iterations, cnt counts WIDTH down to 1
module booth_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t             state;
    state_t             next_state;

    // One bit wider than the operands so that A = -2^(WIDTH-1) negates cleanly.
    logic [WIDTH:0]     m;
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   q;
    logic               q_1;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH:0]     acc_sel;
    logic [2*WIDTH+1:0] shifted;
    logic [WIDTH:0]     acc_next;
    logic [WIDTH-1:0]   q_next;
    logic               q1_next;
    logic               last_iter;

    assign last_iter = (state == CALC) && (cnt == CNT_W'(1));

    // One Booth step: add/subtract M according to {Q[0],q_1}, then shift right arithmetically.
    always_comb begin
        acc_sel = acc;
        case ({q[0], q_1})
            2'b01:   acc_sel = acc + m;
            2'b10:   acc_sel = acc - m;
            default: acc_sel = acc;
        endcase
        shifted  = {acc_sel[WIDTH], acc_sel, q};
        acc_next = shifted[2*WIDTH+1:WIDTH+1];
        q_next   = shifted[WIDTH:1];
        q1_next  = shifted[0];
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: start only matters in IDLE; CALC ends on the last iteration.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CALC;
            CALC:    if (last_iter) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath and registered outputs: load on start, iterate in CALC, publish on the last step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m       <= '0;
            acc     <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    m    <= {A[WIDTH-1], A};
                    acc  <= '0;
                    q    <= B;
                    q_1  <= 1'b0;
                    cnt  <= CNT_W'(WIDTH);
                    busy <= 1'b1;
                end
            end else begin
                acc <= acc_next;
                q   <= q_next;
                q_1 <= q1_next;
                cnt <= cnt - CNT_W'(1);
                if (last_iter) begin
                    product <= {acc_next[WIDTH-1:0], q_next};
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: directed cases plus random operands,
// compared against a plain signed-integer multiply.
module tb_booth_multiplier;

    localparam int WIDTH = 8;

    logic               clk;
    logic               rst;
    logic               start;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    int n_checks = 0;
    int n_errors = 0;

    booth_multiplier #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*WIDTH-1:0] model_product(input logic [WIDTH-1:0] a,
                                                         input logic [WIDTH-1:0] b);
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        return (2*WIDTH)'(sa * sb);
    endfunction

    // One full multiplication with a single-cycle start pulse.
    task automatic do_mult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string tag);
        int cycles;
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, " busy_after_start"}, 32'(busy), 32'd1);
        cycles = 0;
        while (!done && cycles < 4*WIDTH) begin
            @(posedge clk);
            #1;
            cycles++;
            if (!done) check({tag, " busy_during"}, 32'(busy), 32'd1);
        end
        check({tag, " latency"}, 32'(cycles), 32'(WIDTH));
        check({tag, " product"}, 32'(product), 32'(model_product(a, b)));
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " product_held"}, 32'(product), 32'(model_product(a, b)));
    endtask

    initial begin
        int dones;
        int last_done;
        int waited;
        rst   = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset product", 32'(product), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        do_mult(8'd7, 8'd3, "7x3");
        check("7x3 literal", 32'(product), 32'h0015);
        do_mult(8'hFB, 8'd6, "m5x6");
        check("m5x6 literal", 32'(product), 32'hFFE2);
        do_mult(8'h80, 8'h80, "m128xm128");
        check("m128xm128 literal", 32'(product), 32'h4000);
        do_mult(8'h7F, 8'h80, "127xm128");
        check("127xm128 literal", 32'(product), 32'hC080);
        do_mult(8'h5A, 8'h00, "5Ax0");
        do_mult(8'h00, 8'h80, "0x80");

        // Start during CALC and operand changes must be ignored.
        @(negedge clk);
        A = 8'd10;
        B = 8'd10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = 8'h33;
        B = 8'hC4;
        @(negedge clk);
        @(negedge clk);
        A = 8'd2;
        B = 8'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = 8'hE7;
        B = 8'h19;
        dones = 0;
        for (int i = 0; i < 3*WIDTH; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                check("ignore_start product", 32'(product), 32'h0064);
            end
        end
        check("ignore_start done_count", 32'(dones), 32'd1);

        // Asynchronous reset mid-CALC abandons the operation.
        @(negedge clk);
        A = 8'd9;
        B = 8'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst product", 32'(product), 32'd0);
        check("async_rst busy", 32'(busy), 32'd0);
        check("async_rst done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        dones = 0;
        for (int i = 0; i < 2*WIDTH; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("async_rst no_done", 32'(dones), 32'd0);
        do_mult(8'hFF, 8'hFF, "m1xm1");
        check("m1xm1 literal", 32'(product), 32'h0001);

        // Random operands against the integer model.
        for (int i = 0; i < 30; i++) begin
            do_mult(WIDTH'($urandom), WIDTH'($urandom), "random");
        end

        // Start held high restarts right after every completion.
        @(negedge clk);
        A = 8'd3;
        B = 8'hFC;
        start = 1'b1;
        @(posedge clk);
        #1;
        last_done = -1;
        dones = 0;
        for (int k = 1; k <= 3*(WIDTH+1); k++) begin
            @(posedge clk);
            #1;
            check("held busy_vs_done", 32'(busy), 32'(!done));
            if (done) begin
                dones++;
                check("held interval", 32'(k - last_done), 32'(WIDTH+1));
                check("held product", 32'(product), 32'hFFF4);
                last_done = k;
            end
        end
        check("held done_count", 32'(dones), 32'd3);
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (!done && waited < 4*WIDTH) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("held drain_done", 32'(done), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
